// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan display: segment codes,
// controller state type, display-buffer entry type and BCD sizing helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    // Codes 10..15 never occur in valid BCD and fall back to blank.
    localparam logic [6:0] SEG_DIGIT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    typedef struct packed {
        logic       blank;
        logic       minus;
        logic [3:0] nib;
    } digit_t;

    function automatic int bcd_digits(input int width);
        return width * 3 / 10 + 1;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational decoder from one display-buffer entry to common-anode segments.
module seg7_lut
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (minus) begin
            seg = SEG_MINUS;
        end else if (!blank) begin
            seg = SEG_DIGIT[nib];
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Binary-to-decimal converter (sequential double-dabble) feeding a
// multiplexed seven-segment display with blanking, sign and overflow.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BD = bcd_digits(WIDTH);
    localparam int BW = $clog2(WIDTH);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    state_t            state, state_next;
    logic [WIDTH-1:0]  sr, mag;
    logic [4*BD-1:0]   bcd, bcd_adj;
    logic [BW-1:0]     bit_cnt;
    logic              neg, neg_in, load_ovf;
    int                msd, sig;
    digit_t            disp [DIGITS];
    digit_t            disp_next [DIGITS];
    digit_t            load_digits [DIGITS];
    digit_t            cur_digit;
    logic [CW-1:0]     cnt, cnt_next;
    logic [IW-1:0]     idx, idx_next;
    logic [6:0]        seg_next;

    // The magnitude is formed one bit wider so the most negative value negates cleanly.
    always_comb begin
        neg_in = (SIGNED != 0) && value[WIDTH-1];
        mag    = value;
        if (neg_in) begin
            mag = WIDTH'(~{value[WIDTH-1], value} + (WIDTH+1)'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (bit_cnt == BW'(WIDTH-1)) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == LOAD);
    end

    always_comb begin
        bcd_adj = bcd;
        for (int j = 0; j < BD; j++) begin
            if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            neg     <= 1'b0;
        end else if (state == IDLE && start) begin
            sr      <= mag;
            bcd     <= '0;
            bit_cnt <= '0;
            neg     <= neg_in;
        end else if (state == CONVERT) begin
            {bcd, sr} <= {bcd_adj, sr} << 1;
            bit_cnt   <= bit_cnt + BW'(1);
        end
    end

    // Build the blanked, signed digit image that LOAD commits to the buffer.
    always_comb begin
        msd = 0;
        for (int j = 0; j < BD; j++) begin
            if (bcd[4*j +: 4] != 4'd0) msd = j;
        end
        sig      = msd + 1;
        load_ovf = (sig + (neg ? 1 : 0)) > DIGITS;
        for (int i = 0; i < DIGITS; i++) begin
            load_digits[i] = '{blank: 1'b1, minus: 1'b0, nib: 4'd0};
            if (load_ovf) begin
                load_digits[i].blank = 1'b0;
                load_digits[i].minus = 1'b1;
            end else if (i < sig) begin
                load_digits[i].blank = 1'b0;
                for (int j = 0; j < BD; j++) begin
                    if (j == i) load_digits[i].nib = bcd[4*j +: 4];
                end
            end else if (neg && i == sig) begin
                load_digits[i].blank = 1'b0;
                load_digits[i].minus = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            disp_next[i] = (state == LOAD) ? load_digits[i] : disp[i];
        end
        cnt_next = (cnt == CW'(REFRESH_DIV-1)) ? '0 : cnt + CW'(1);
        idx_next = idx;
        if (cnt == CW'(REFRESH_DIV-1)) begin
            idx_next = (idx == IW'(DIGITS-1)) ? '0 : idx + IW'(1);
        end
        cur_digit = disp_next[idx_next];
    end

    seg7_lut u_lut (
        .nib   (cur_digit.nib),
        .blank (cur_digit.blank),
        .minus (cur_digit.minus),
        .seg   (seg_next)
    );

    // Segments are decoded from the next buffer/index so seg and an change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp[i] <= '{blank: 1'b1, minus: 1'b0, nib: 4'd0};
            end
            cnt      <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= '1;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                disp[i] <= disp_next[i];
            end
            cnt <= cnt_next;
            idx <= idx_next;
            seg <= seg_next;
            an  <= ~(DIGITS'(1) << idx_next);
            if (state == LOAD) overflow <= load_ovf;
        end
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter WIDTH, default 8, binary input width (4..16).
REQ-002 Parameter DIGITS, default 4, number of multiplexed display digits (1..8).
REQ-003 Parameter SIGNED, default 1, 1 = value is two's complement, 0 = unsigned.
REQ-004 Parameter REFRESH_DIV, default 50000, clk cycles per digit scan slot (>=2).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle request to convert and display value.
REQ-008 value  input  WIDTH  number to display, sampled on accepted start.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when new digits are loaded into the display buffer.
REQ-011 overflow  output  1  high while the displayed number does not fit in DIGITS.
REQ-012 seg  output  7  common-anode segments {a,b,c,d,e,f,g}, 0 = lit.
REQ-013 an  output  DIGITS  digit enables, active-low one-hot; an[0] = rightmost digit.

Function
REQ-014 FSM states: IDLE, CONVERT, LOAD; reset state IDLE.
REQ-015 IDLE: start=1 latches value, sets busy, enters CONVERT; start in CONVERT or LOAD is ignored.
REQ-016 Sign: SIGNED=1 and value MSB=1 gives neg=1 and magnitude = two's complement of value (WIDTH+1-bit arithmetic, so -2^(WIDTH-1) converts correctly); otherwise neg=0, magnitude = value.
REQ-017 CONVERT: sequential double-dabble, one shift per cycle, exactly WIDTH cycles, add-3 applied to every BCD nibble >=5 before each shift.
REQ-018 BCD result holds BCD_DIGITS = WIDTH*3/10+1 nibbles.
REQ-019 LOAD: display buffer, neg flag and overflow update in one cycle; done pulses that cycle; busy drops; return to IDLE.
REQ-020 Latency: start accepted in cycle 0 -> done high in cycle WIDTH+1 -> display shows new data from cycle WIDTH+2; next start is accepted in cycle WIDTH+2.
REQ-021 Until a new LOAD, the display buffer holds the previous result.
REQ-022 Leading-zero blanking: digits left of the most significant non-zero digit are blank; value 0 shows a single '0' in digit 0.
REQ-023 Minus: when neg=1, '-' (only g lit) is placed in the digit immediately left of the most significant digit.
REQ-024 Overflow: significant digits plus the sign digit > DIGITS sets overflow=1, and every digit shows '-'.
REQ-025 Scan: the refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap the digit index advances and wraps from DIGITS-1 to 0.
REQ-026 an drives low only the bit of the current index; seg is the registered encoding of that digit, aligned with an in the same cycle.
REQ-027 Encoding 0-9 uses the team table (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100), blank = 1111111, minus = 1111110.
REQ-028 Scanning runs continuously, independent of the FSM; a LOAD never resets the scan index.

Reset
REQ-029 rst_n low: state IDLE, busy=0, done=0, overflow=0, display buffer all blank, scan index 0, refresh counter 0, seg=1111111, an all ones.
REQ-030 Reset during CONVERT aborts the conversion, with no done and no buffer update.
REQ-031 After release, the display is blank (an scanning, seg=1111111) until the first LOAD.

Structure
REQ-032 Shared package seg_pkg holds the segment constants (SEG_BLANK, SEG_MINUS, digit table), the FSM state typedef and the BCD_DIGITS width function.
REQ-033 One sub-module seg7_lut: combinational nibble plus blank/minus flags to seg; instantiated once, on the scan path.

Verification
REQ-034 WIDTH=8, DIGITS=4, SIGNED=1, start with value=8'h7F -> done in cycle 9; digits (3..0) = blank,1,2,7; overflow=0.
REQ-035 value=8'hF6 (-10) -> digits = blank,-,1,0; value=8'h00 -> blank,blank,blank,0.
REQ-036 DIGITS=3, value=8'h80 (-128) -> overflow=1, all three digits show 1111110; then value=8'h05 -> overflow=0, digits = blank,blank,5.
REQ-037 REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111, each held 4 cycles, repeating, with seg matching each slot.
REQ-038 Start pulsed again 3 cycles after an accepted start -> ignored, exactly one done, result of the first value; rst_n low in CONVERT cycle 4 -> no done, display blank, an=1111.
REQ-039 SIGNED=0, WIDTH=10, value=10'd1023 -> digits 1,0,2,3, done in cycle 11.
